umi_gpio_mirror: RTL and testbench
==================================

// Module: umi_gpio_mirror
// PURPOSE
//  UMI host-side stage sitting directly upstream of a UMI GPIO device. It
//  watches a local parallel bus and, whenever that bus differs from the last
//  value successfully delivered, issues a single-flit UMI write (or posted
//  write) carrying the bus value. The downstream GPIO output thus mirrors
//  mirror_in. A rate limiter spaces sends; failed writes are retried.
// PARAMETERS
//  DW=256        UMI data width (bits)
//  AW=64         UMI address width (bits)
//  CW=32         UMI command width (bits)
//  WIDTH=32      mirrored bus width; multiple of 8, 8..DW
//  DSTADDR=0     [AW-1:0] request dstaddr (GPIO device address)
//  SRCADDR=0     [AW-1:0] request srcaddr (response return address)
//  POSTED=0      1: UMI_REQ_POSTED, no response; 0: UMI_REQ_WRITE, wait for response
//  HOLDOFF=16    minimum idle cycles after each completed send (0 = none)
// PORTS
//  clk                 in   1      clock
//  nreset              in   1      async active-low reset
//  mirror_in           in   WIDTH  local value to mirror
//  force_send          in   1      pulse: send even if unchanged
//  busy                out  1      FSM not in IDLE
//  in_sync             out  1      IDLE and last_sent == mirror_in
//  err_pulse           out  1      1-cycle pulse on bad write response
//  uhost_req_valid     out  1      request valid
//  uhost_req_cmd       out  CW     request command
//  uhost_req_dstaddr   out  AW     = DSTADDR
//  uhost_req_srcaddr   out  AW     = SRCADDR
//  uhost_req_data      out  DW     snapshot, zero-extended
//  uhost_req_ready     in   1      request ready
//  uhost_resp_valid    in   1      response valid
//  uhost_resp_cmd      in   CW     response command
//  uhost_resp_dstaddr  in   AW     ignored
//  uhost_resp_srcaddr  in   AW     ignored
//  uhost_resp_data     in   DW     ignored
//  uhost_resp_ready    out  1      response ready
// BEHAVIOUR
//  Clock is clk; reset is nreset, asynchronous, active-low.
//  Reset (async, immediate):
//   - state=IDLE; last_sent=0; snapshot=0; holdoff counter=0.
//   - pend_force=1, so the first value is always sent after reset.
//   - All outputs 0; data/cmd 0. Reset mid-transfer drops req_valid at once;
//     a lost response is not tracked.
//  Request cmd:
//   - opcode per POSTED; size=0; len=WIDTH/8-1; eom=1.
//   - atype/qos/prot/eof/ex/user/user_extended/err/hostid=0.
//  State machine:
//   - IDLE: if pend_force or force_send or mirror_in!=last_sent, latch
//     snapshot<=mirror_in, clear pend_force, go REQ. No UMI activity.
//   - REQ: req_valid=1; cmd/data stable until ready.
//     On valid&&ready: POSTED=1 -> last_sent<=snapshot, go HOLD;
//     else go WAIT.
//   - WAIT: resp_ready=1. On resp_valid:
//     . opcode==UMI_RESP_WRITE && err==0 -> last_sent<=snapshot.
//     . else err_pulse=1 next cycle; last_sent unchanged (retry).
//     . then go HOLD.
//   - HOLD: count HOLDOFF cycles, then IDLE. HOLDOFF=0 goes straight to
//     IDLE, so the min gap is 1 idle cycle.
//  Boundary conditions:
//   - mirror_in changes during REQ/WAIT/HOLD: not resampled. Difference is
//     detected in IDLE and resent. The final value is always eventually sent.
//   - force_send outside IDLE: sets pend_force, consumed at next IDLE.
//   - Simultaneous force_send and change in IDLE: single send.
//   - resp_ready is 0 outside WAIT; responses there are not consumed.
//  Latency: change in IDLE -> req_valid after 1 cycle (registered).
// TESTING
//  T1 reset release, mirror_in=0xA5A5A5A5, POSTED=0 -> req opcode WRITE,
//     len=3, size=0, data[31:0]=A5A5A5A5; after resp, in_sync=1.
//  T2 stall: hold req_ready=0 10 cycles, toggle mirror_in -> req_valid/data
//     stable throughout; second write with new value after HOLDOFF.
//  T3 response err=2'b01 -> err_pulse one cycle; resend same data after
//     HOLDOFF+1 cycles.
//  T4 POSTED=1, 3 changes 2 cycles apart -> sends spaced >=HOLDOFF+1;
//     last sent value = final mirror_in.
//  T5 force_send with mirror_in==last_sent -> exactly one identical write.
//  T6 nreset low while in WAIT -> req_valid=0 and busy=0 immediately;
//     after release, fresh send of current mirror_in.

Source files
------------

// File: rtl/umi_gpio_mirror.sv
// Mirrors a local parallel bus onto a downstream UMI GPIO device using single-flit
// writes. A write is sent on change, on force, after reset, and again after a failed write.
//
// state | meaning
// IDLE  | compare mirror_in with the last delivered value and launch a send if needed
// REQ   | request flit presented, holding until uhost_req_ready
// WAIT  | non-posted write issued, waiting for its write response
// HOLD  | rate-limit gap after a completed send, then back to IDLE
module umi_gpio_mirror #(
   parameter int            DW      = 256,
   parameter int            AW      = 64,
   parameter int            CW      = 32,
   parameter int            WIDTH   = 32,
   parameter logic [AW-1:0] DSTADDR = '0,
   parameter logic [AW-1:0] SRCADDR = '0,
   parameter bit            POSTED  = 1'b0,
   parameter int            HOLDOFF = 16
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic [WIDTH-1:0] mirror_in,
   input  logic             force_send,
   output logic             busy,
   output logic             in_sync,
   output logic             err_pulse,
   output logic             uhost_req_valid,
   output logic [CW-1:0]    uhost_req_cmd,
   output logic [AW-1:0]    uhost_req_dstaddr,
   output logic [AW-1:0]    uhost_req_srcaddr,
   output logic [DW-1:0]    uhost_req_data,
   input  logic             uhost_req_ready,
   input  logic             uhost_resp_valid,
   input  logic [CW-1:0]    uhost_resp_cmd,
   input  logic [AW-1:0]    uhost_resp_dstaddr,
   input  logic [AW-1:0]    uhost_resp_srcaddr,
   input  logic [DW-1:0]    uhost_resp_data,
   output logic             uhost_resp_ready
);

   localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
   localparam logic [4:0] UMI_RESP_WRITE = 5'h04;
   localparam logic [4:0] UMI_REQ_POSTED = 5'h05;

   localparam logic [4:0]    REQ_OPCODE = POSTED ? UMI_REQ_POSTED : UMI_REQ_WRITE;
   localparam logic [7:0]    REQ_LEN    = 8'(WIDTH / 8 - 1);
   // opcode[4:0] size[7:5] len[15:8] qos/prot[21:16] eom[22], everything above zero
   localparam logic [31:0]   CMD32      = {9'b0, 1'b1, 6'b0, REQ_LEN, 3'b000, REQ_OPCODE};
   localparam logic [CW-1:0] REQ_CMD    = CW'(CMD32);

   localparam int            HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] last_sent;
   logic [WIDTH-1:0] snapshot;
   logic [HW-1:0]    hold_cnt;
   logic             pend_force;

   logic [4:0] resp_opcode;
   logic [1:0] resp_err;
   logic       resp_ok;
   logic       unused_resp;

   assign resp_opcode = uhost_resp_cmd[4:0];
   assign resp_err    = uhost_resp_cmd[26:25];
   assign resp_ok     = (resp_opcode == UMI_RESP_WRITE) && (resp_err == 2'b00);
   assign unused_resp = ^{uhost_resp_dstaddr, uhost_resp_srcaddr, uhost_resp_data,
                          uhost_resp_cmd[CW-1:27], uhost_resp_cmd[24:5]};

   assign uhost_req_dstaddr = DSTADDR;
   assign uhost_req_srcaddr = SRCADDR;

   // A pending force means a send is owed, so the mirror is not yet in sync
   assign in_sync = (state == IDLE) && !pend_force && (last_sent == mirror_in);

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state            <= IDLE;
         last_sent        <= '0;
         snapshot         <= '0;
         hold_cnt         <= '0;
         pend_force       <= 1'b1;
         busy             <= 1'b0;
         err_pulse        <= 1'b0;
         uhost_req_valid  <= 1'b0;
         uhost_req_cmd    <= '0;
         uhost_req_data   <= '0;
         uhost_resp_ready <= 1'b0;
      end else begin
         err_pulse <= 1'b0;
         if ((state != IDLE) && force_send)
            pend_force <= 1'b1;
         case (state)
            IDLE: begin
               if (pend_force || force_send || (mirror_in != last_sent)) begin
                  snapshot        <= mirror_in;
                  pend_force      <= 1'b0;
                  state           <= REQ;
                  busy            <= 1'b1;
                  uhost_req_valid <= 1'b1;
                  uhost_req_cmd   <= REQ_CMD;
                  uhost_req_data  <= DW'(mirror_in);
               end
            end
            REQ: begin
               if (uhost_req_ready) begin
                  uhost_req_valid <= 1'b0;
                  if (POSTED) begin
                     last_sent <= snapshot;
                     if (HOLDOFF == 0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end else begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_LOAD;
                     end
                  end else begin
                     state            <= WAIT;
                     uhost_resp_ready <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (uhost_resp_valid) begin
                  uhost_resp_ready <= 1'b0;
                  // a failed write leaves last_sent alone so IDLE resends it
                  if (resp_ok)
                     last_sent <= snapshot;
                  else
                     err_pulse <= 1'b1;
                  if (HOLDOFF == 0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state    <= HOLD;
                     hold_cnt <= HOLD_LOAD;
                  end
               end
            end
            HOLD: begin
               if (hold_cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt - HW'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_umi_gpio_mirror.sv
// Bench for umi_gpio_mirror: a non-posted instance (HOLDOFF=4) and a posted
// instance (HOLDOFF=3) checked every cycle against a send-level model.
module tb_umi_gpio_mirror;
   localparam int DW = 64;
   localparam int AW = 64;
   localparam int CW = 32;
   localparam int WIDTH = 32;
   localparam logic [AW-1:0] DST = 64'h0000_0000_4000_0010;
   localparam logic [AW-1:0] SRC = 64'h0000_0000_0000_0200;

   localparam int P_IDLE = 0;
   localparam int P_REQ  = 1;
   localparam int P_WAIT = 2;
   localparam int P_HOLD = 3;

   logic clk = 1'b0;
   logic nreset = 1'b0;
   logic [31:0] mi [2];
   logic        fs [2];
   logic        rdy [2];
   logic        rv [2];
   logic [31:0] rc [2];
   logic        busy_o [2];
   logic        sync_o [2];
   logic        err_o [2];
   logic        val_o [2];
   logic        rr_o [2];
   logic [31:0] cmd_o [2];
   logic [63:0] dst_o [2];
   logic [63:0] src_o [2];
   logic [63:0] data_o [2];
   logic [63:0] zero64 = '0;

   int checks = 0;
   int errors = 0;

   // send-level model state
   int          ph [2];
   int          quiet [2];
   logic        pend [2];
   logic        err_due [2];
   logic [31:0] last [2];
   logic [31:0] snap [2];
   logic [31:0] sent0 [$];
   logic [31:0] sent1 [$];
   int          acc1 [$];
   int          ncyc = 0;

   logic [31:0] exp0 [8] = '{32'hA5A5A5A5, 32'h12345678, 32'h0F0F0F0F, 32'hCAFEBABE,
                             32'hCAFEBABE, 32'hCAFEBABE, 32'h55AA55AA, 32'h55AA55AA};
   logic [31:0] exp1 [4] = '{32'h0, 32'h11, 32'h33, 32'h33};

   always #5 clk = ~clk;

   umi_gpio_mirror #(.DW(DW), .AW(AW), .CW(CW), .WIDTH(WIDTH), .DSTADDR(DST),
                     .SRCADDR(SRC), .POSTED(1'b0), .HOLDOFF(4)) u_dut0 (
      .clk(clk), .nreset(nreset), .mirror_in(mi[0]), .force_send(fs[0]),
      .busy(busy_o[0]), .in_sync(sync_o[0]), .err_pulse(err_o[0]),
      .uhost_req_valid(val_o[0]), .uhost_req_cmd(cmd_o[0]),
      .uhost_req_dstaddr(dst_o[0]), .uhost_req_srcaddr(src_o[0]),
      .uhost_req_data(data_o[0]), .uhost_req_ready(rdy[0]),
      .uhost_resp_valid(rv[0]), .uhost_resp_cmd(rc[0]),
      .uhost_resp_dstaddr(zero64), .uhost_resp_srcaddr(zero64),
      .uhost_resp_data(zero64), .uhost_resp_ready(rr_o[0]));

   umi_gpio_mirror #(.DW(DW), .AW(AW), .CW(CW), .WIDTH(WIDTH), .DSTADDR(DST),
                     .SRCADDR(SRC), .POSTED(1'b1), .HOLDOFF(3)) u_dut1 (
      .clk(clk), .nreset(nreset), .mirror_in(mi[1]), .force_send(fs[1]),
      .busy(busy_o[1]), .in_sync(sync_o[1]), .err_pulse(err_o[1]),
      .uhost_req_valid(val_o[1]), .uhost_req_cmd(cmd_o[1]),
      .uhost_req_dstaddr(dst_o[1]), .uhost_req_srcaddr(src_o[1]),
      .uhost_req_data(data_o[1]), .uhost_req_ready(rdy[1]),
      .uhost_resp_valid(rv[1]), .uhost_resp_cmd(rc[1]),
      .uhost_resp_dstaddr(zero64), .uhost_resp_srcaddr(zero64),
      .uhost_resp_data(zero64), .uhost_resp_ready(rr_o[1]));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Checks outputs against the model, then advances the model with the inputs
   // the coming posedge will see.
   always @(negedge clk) begin
      logic [31:0] ecmd;
      int          hold;
      bit          posted;
      logic        ok;
      ncyc++;
      for (int i = 0; i < 2; i++) begin
         posted = (i == 1);
         hold   = (i == 0) ? 4 : 3;
         ecmd   = posted ? 32'h0040_0305 : 32'h0040_0303;
         chk("dstaddr", dst_o[i], DST);
         chk("srcaddr", src_o[i], SRC);
         if (!nreset) begin
            chk("rst_busy", busy_o[i], 0);
            chk("rst_req_valid", val_o[i], 0);
            chk("rst_resp_ready", rr_o[i], 0);
            chk("rst_err_pulse", err_o[i], 0);
            chk("rst_in_sync", sync_o[i], 0);
            chk("rst_cmd", cmd_o[i], 0);
            chk("rst_data", data_o[i], 0);
            ph[i] = P_IDLE; quiet[i] = 0; pend[i] = 1'b1; err_due[i] = 1'b0;
            last[i] = '0; snap[i] = '0;
         end else begin
            chk("busy", busy_o[i], ph[i] != P_IDLE);
            chk("req_valid", val_o[i], ph[i] == P_REQ);
            chk("resp_ready", rr_o[i], ph[i] == P_WAIT);
            chk("err_pulse", err_o[i], err_due[i]);
            chk("in_sync", sync_o[i], (ph[i] == P_IDLE) && !pend[i] && (mi[i] == last[i]));
            if (ph[i] == P_REQ) begin
               chk("req_cmd", cmd_o[i], ecmd);
               chk("req_data", data_o[i], {32'h0, snap[i]});
            end
            err_due[i] = 1'b0;
            if (ph[i] != P_IDLE && fs[i]) pend[i] = 1'b1;
            case (ph[i])
               P_IDLE: begin
                  if (pend[i] || fs[i] || mi[i] != last[i]) begin
                     snap[i] = mi[i];
                     pend[i] = 1'b0;
                     ph[i]   = P_REQ;
                  end
               end
               P_REQ: begin
                  if (rdy[i]) begin
                     if (i == 0) sent0.push_back(data_o[0][31:0]);
                     else begin
                        sent1.push_back(data_o[1][31:0]);
                        acc1.push_back(ncyc);
                     end
                     if (posted) begin
                        last[i] = snap[i];
                        if (hold == 0) ph[i] = P_IDLE;
                        else begin ph[i] = P_HOLD; quiet[i] = hold; end
                     end else begin
                        ph[i] = P_WAIT;
                     end
                  end
               end
               P_WAIT: begin
                  if (rv[i]) begin
                     ok = (rc[i][4:0] == 5'h04) && (rc[i][26:25] == 2'b00);
                     if (ok) last[i] = snap[i];
                     else err_due[i] = 1'b1;
                     if (hold == 0) ph[i] = P_IDLE;
                     else begin ph[i] = P_HOLD; quiet[i] = hold; end
                  end
               end
               default: begin
                  quiet[i]--;
                  if (quiet[i] == 0) ph[i] = P_IDLE;
               end
            endcase
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_valid(input int i, output int n);
      n = 0;
      while (val_o[i] !== 1'b1 && n < 30) begin cyc(1); n++; end
      chk("wait_req_valid", val_o[i], 1);
   endtask

   task automatic send_resp(input logic [31:0] c);
      int n;
      n = 0;
      while (rr_o[0] !== 1'b1 && n < 30) begin cyc(1); n++; end
      chk("wait_resp_ready", rr_o[0], 1);
      rv[0] = 1'b1; rc[0] = c;
      cyc(1);
      rv[0] = 1'b0; rc[0] = '0;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 2; i++) begin
         mi[i] = '0; fs[i] = 1'b0; rdy[i] = 1'b1; rv[i] = 1'b0; rc[i] = '0;
      end
      mi[0] = 32'hA5A5A5A5;
      nreset = 1'b0;
      cyc(3);
      chk("t0_busy", busy_o[0], 0);
      chk("t0_req_valid", val_o[0], 0);

      // T1: first value after reset, non-posted write
      nreset = 1'b1;
      cyc(1);
      chk("t1_req_valid", val_o[0], 1);
      chk("t1_cmd", cmd_o[0], 32'h0040_0303);
      chk("t1_data", data_o[0], 64'hA5A5A5A5);
      chk("t4_cmd_posted", cmd_o[1], 32'h0040_0305);
      send_resp(32'h0000_0004);
      cyc(6);
      chk("t1_in_sync", sync_o[0], 1);

      // T2: stalled request stays stable while mirror_in moves
      rdy[0] = 1'b0;
      mi[0] = 32'h12345678;
      cyc(1);
      chk("t2_req_valid", val_o[0], 1);
      for (int k = 0; k < 10; k++) begin
         mi[0] = k[0] ? 32'hFFFF0000 : 32'h0000FFFF;
         cyc(1);
         chk("t2_stall_valid", val_o[0], 1);
         chk("t2_stall_data", data_o[0], 64'h12345678);
      end
      mi[0] = 32'h0F0F0F0F;
      rdy[0] = 1'b1;
      send_resp(32'h0000_0004);
      wait_valid(0, n);
      chk("t2_gap", n, 5);
      chk("t2_second_data", data_o[0], 64'h0F0F0F0F);
      send_resp(32'h0000_0004);
      cyc(8);

      // T3: error response -> err_pulse and resend of the same data
      mi[0] = 32'hCAFEBABE;
      wait_valid(0, n);
      send_resp(32'h0200_0004);
      chk("t3_err_pulse", err_o[0], 1);
      wait_valid(0, n);
      chk("t3_retry_gap", n, 5);
      chk("t3_retry_data", data_o[0], 64'hCAFEBABE);
      send_resp(32'h0000_0004);
      cyc(8);
      chk("t3_in_sync", sync_o[0], 1);

      // T5: force with unchanged value -> one identical write
      fs[0] = 1'b1;
      cyc(1);
      fs[0] = 1'b0;
      chk("t5_req_valid", val_o[0], 1);
      chk("t5_data", data_o[0], 64'hCAFEBABE);
      send_resp(32'h0000_0004);
      cyc(10);
      chk("t5_no_extra", val_o[0], 0);
      chk("t5_in_sync", sync_o[0], 1);

      // T4: posted instance, three changes two cycles apart
      mi[1] = 32'h11;
      cyc(2);
      mi[1] = 32'h22;
      cyc(2);
      mi[1] = 32'h33;
      cyc(12);
      chk("t4_in_sync", sync_o[1], 1);

      // T6: reset while waiting for the response
      mi[0] = 32'h55AA55AA;
      wait_valid(0, n);
      chk("t6_first_data", data_o[0], 64'h55AA55AA);
      n = 0;
      while (rr_o[0] !== 1'b1 && n < 30) begin cyc(1); n++; end
      chk("t6_in_wait", rr_o[0], 1);
      nreset = 1'b0;
      #1;
      chk("t6_busy", busy_o[0], 0);
      chk("t6_req_valid", val_o[0], 0);
      chk("t6_resp_ready", rr_o[0], 0);
      @(posedge clk);
      #2;
      nreset = 1'b1;
      wait_valid(0, n);
      chk("t6_latency", n, 1);
      chk("t6_resend_data", data_o[0], 64'h55AA55AA);
      send_resp(32'h0000_0004);
      cyc(10);
      chk("t6_in_sync", sync_o[0], 1);

      chk("q0_size", sent0.size(), 8);
      for (int k = 0; k < 8 && k < sent0.size(); k++) chk("q0_data", sent0[k], exp0[k]);
      chk("q1_size", sent1.size(), 4);
      for (int k = 0; k < 4 && k < sent1.size(); k++) chk("q1_data", sent1[k], exp1[k]);
      if (acc1.size() >= 3) chk("t4_send_spacing", acc1[2] - acc1[1], 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
      $fatal(1);
   end

endmodule
